// File: rtl/bram_result_reader_pkg.sv
// rtl/bram_result_reader_pkg.sv - shared state encoding and default sizes for the BRAM result reader
package bram_result_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   localparam int CNT_BIT_DEF  = 31;
   localparam int DWIDTH_DEF   = 64;
   localparam int AWIDTH_DEF   = 8;
   localparam int MEM_SIZE_DEF = 256;

   // Reads are throttled so buffered plus in-flight words never exceed this
   localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/bram_result_reader_fifo2.sv
// rtl/bram_result_reader_fifo2.sv - two-entry result FIFO, slot0 is always the head
module result_fifo2
   import bram_result_reader_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push_i,
   input  logic [DWIDTH-1:0] push_data_i,
   input  logic              pop_i,
   output logic              full_o,
   output logic              empty_o,
   output logic [1:0]        count_o,
   output logic [DWIDTH-1:0] head_o
);

   logic [DWIDTH-1:0] slot0_q, slot0_d;
   logic [DWIDTH-1:0] slot1_q, slot1_d;
   logic [1:0]        count_q, count_d;

   always_comb begin
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      count_d = count_q;
      case ({push_i, pop_i})
         2'b10: begin
            if (count_q == 2'd0) slot0_d = push_data_i;
            else                 slot1_d = push_data_i;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            slot0_d = slot1_q;
            count_d = count_q - 2'd1;
         end
         // Push and pop together: the pushed word lands behind whatever stays
         2'b11: begin
            if (count_q == 2'd1) begin
               slot0_d = push_data_i;
            end else begin
               slot0_d = slot1_q;
               slot1_d = push_data_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot0_q <= '0;
         slot1_q <= '0;
         count_q <= 2'd0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         count_q <= count_d;
      end
   end

   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);
   assign count_o = count_q;
   assign head_o  = slot0_q;

endmodule

// File: rtl/bram_result_reader.sv
// rtl/bram_result_reader.sv - drains N words from BRAM port 1 into a ready/valid stream
module bram_result_reader
   import bram_result_reader_pkg::*;
#(
   parameter int CNT_BIT  = CNT_BIT_DEF,
   parameter int DWIDTH   = DWIDTH_DEF,
   parameter int AWIDTH   = AWIDTH_DEF,
   parameter int MEM_SIZE = MEM_SIZE_DEF
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start_run_i,
   input  logic [CNT_BIT-1:0] run_count_i,
   output logic [AWIDTH-1:0]  addr_b1_o,
   output logic               ce_b1_o,
   output logic               we_b1_o,
   input  logic [DWIDTH-1:0]  q_b1_i,
   output logic               m_valid_o,
   input  logic               m_ready_i,
   output logic [DWIDTH-1:0]  m_data_o,
   output logic               idle_o,
   output logic               run_o,
   output logic               done_o
);

   if (MEM_SIZE > (1 << AWIDTH)) begin : g_mem_size_check
      $error("MEM_SIZE does not fit in the BRAM address width");
   end

   state_e             state_q, state_d;
   logic [CNT_BIT-1:0] n_q, n_d;
   logic [CNT_BIT-1:0] issue_q, issue_d;
   logic [CNT_BIT-1:0] accept_q, accept_d;
   logic               inflight_q, inflight_d;
   logic               idle_q, idle_d;
   logic               run_q, run_d;
   logic               done_q, done_d;

   logic               fifo_full, fifo_empty, fifo_push, fifo_pop, issue;
   logic [1:0]         fifo_count;
   logic [2:0]         occupancy;
   logic [DWIDTH-1:0]  fifo_head;

   assign fifo_pop  = m_valid_o && m_ready_i;
   assign fifo_push = inflight_q && (!fifo_full || fifo_pop);

   // The word leaving this cycle frees its slot, keeping back-to-back reads going
   assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, fifo_pop};
   assign issue     = (state_q == ST_RUN) && (issue_q < n_q) && (occupancy < 3'(FIFO_DEPTH));

   assign ce_b1_o   = issue;
   assign addr_b1_o = issue_q[AWIDTH-1:0];
   assign we_b1_o   = 1'b0;
   assign m_valid_o = !fifo_empty;
   assign m_data_o  = fifo_head;
   assign idle_o    = idle_q;
   assign run_o     = run_q;
   assign done_o    = done_q;

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      issue_d    = issue_q;
      accept_d   = accept_q;
      inflight_d = issue;
      if (issue)    issue_d  = issue_q + CNT_BIT'(1);
      if (fifo_pop) accept_d = accept_q + CNT_BIT'(1);
      case (state_q)
         ST_IDLE: begin
            if (start_run_i) begin
               n_d      = run_count_i;
               issue_d  = '0;
               accept_d = '0;
               state_d  = (run_count_i == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (fifo_pop && (accept_d == n_q)) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      idle_d = (state_d == ST_IDLE);
      run_d  = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         n_q        <= '0;
         issue_q    <= '0;
         accept_q   <= '0;
         inflight_q <= 1'b0;
         idle_q     <= 1'b1;
         run_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         issue_q    <= issue_d;
         accept_q   <= accept_d;
         inflight_q <= inflight_d;
         idle_q     <= idle_d;
         run_q      <= run_d;
         done_q     <= done_d;
      end
   end

   result_fifo2 #(
      .DWIDTH(DWIDTH)
   ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push_i     (fifo_push),
      .push_data_i(q_b1_i),
      .pop_i      (fifo_pop),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count),
      .head_o     (fifo_head)
   );

endmodule

// File: tb/tb_bram_result_reader.sv
// tb/tb_bram_result_reader.sv - self-checking bench for bram_result_reader
module tb_bram_result_reader;

   localparam int DW = 64;
   localparam int AW = 8;
   localparam int CB = 31;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          start_run_i = 1'b0;
   logic [CB-1:0] run_count_i = '0;
   logic [AW-1:0] addr_b1_o;
   logic          ce_b1_o, we_b1_o;
   logic [DW-1:0] q_b1_i = '0;
   logic          m_valid_o;
   logic          m_ready_i = 1'b0;
   logic [DW-1:0] m_data_o;
   logic          idle_o, run_o, done_o;

   bram_result_reader dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start_run_i(start_run_i),
      .run_count_i(run_count_i),
      .addr_b1_o  (addr_b1_o),
      .ce_b1_o    (ce_b1_o),
      .we_b1_o    (we_b1_o),
      .q_b1_i     (q_b1_i),
      .m_valid_o  (m_valid_o),
      .m_ready_i  (m_ready_i),
      .m_data_o   (m_data_o),
      .idle_o     (idle_o),
      .run_o      (run_o),
      .done_o     (done_o)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [0:255];
   always @(posedge clk) if (ce_b1_o) q_b1_i <= mem[addr_b1_o];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] word(input int i);
      return {16'(i), 16'(i + 1), 16'(i + 2), 16'(i + 3)};
   endfunction

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   logic [DW-1:0] sb[$];
   int n_cur, issued, accepted, held, infl, done_cnt, done_cyc, start_cyc;
   int first_ce, last_ce, first_acc, last_acc;
   logic stall_prev = 1'b0;
   logic [DW-1:0] stall_data;

   // Called once per cycle at the falling edge; tracks buffered words independently
   task automatic sample();
      int acc;
      acc = (m_valid_o && m_ready_i) ? 1 : 0;
      check("valid_vs_buffered", m_valid_o, held > 0);
      if (ce_b1_o) begin
         check("addr_order", addr_b1_o, issued[AW-1:0]);
         check("ce_credit", (held - acc + infl) < 2, 1'b1);
         check("ce_limit", issued < n_cur, 1'b1);
         check("we_zero", we_b1_o, 1'b0);
         if (issued == 0) first_ce = cyc;
         last_ce = cyc;
         issued++;
      end
      if (acc == 1) begin
         if (sb.size() == 0) check("extra_word", m_data_o, '0);
         else                check("data", m_data_o, sb.pop_front());
         if (accepted == 0) first_acc = cyc;
         last_acc = cyc;
         accepted++;
      end
      if (stall_prev && m_valid_o) check("hold_stable", m_data_o, stall_data);
      stall_prev = m_valid_o && !m_ready_i;
      stall_data = m_data_o;
      if (done_o) begin
         done_cnt++;
         done_cyc = cyc;
      end
      held = held - acc + infl;
      infl = ce_b1_o ? 1 : 0;
   endtask

   task automatic begin_run(input int n);
      start_run_i = 1'b1;
      run_count_i = CB'(n);
      n_cur = n; issued = 0; accepted = 0; done_cnt = 0; start_cyc = cyc;
      for (int i = 0; i < n; i++) sb.push_back(word(i % 256));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_flags"}, {idle_o, run_o, done_o}, 3'b100);
      check({tag, "_bram"}, {ce_b1_o, we_b1_o, addr_b1_o}, '0);
      check({tag, "_valid"}, m_valid_o, 1'b0);
      check({tag, "_data"}, m_data_o, '0);
   endtask

   // mode 0: ready held high, 1: ready toggles, 2: ready low for the first 12 cycles
   task automatic run_case(input int n, input int mode, input int restart_at, input int exp_words);
      int  c;
      bit  fin;
      @(posedge clk); #1;
      m_ready_i = (mode != 2);
      begin_run(n);
      @(negedge clk); sample();
      @(posedge clk); #1;
      start_run_i = 1'b0;
      c = 0; fin = 0;
      while (!fin && c < 2000) begin
         case (mode)
            1:       m_ready_i = (c % 2 == 0);
            2:       m_ready_i = (c >= 12);
            default: m_ready_i = 1'b1;
         endcase
         if (c == restart_at) begin
            check("restart_in_run", run_o, 1'b1);
            start_run_i = 1'b1;
            run_count_i = CB'(3);
         end else begin
            start_run_i = 1'b0;
         end
         if (mode == 2 && c == 12) check("stall_reads", issued, 2);
         @(negedge clk); sample();
         if (done_cnt > 0) fin = 1;
         @(posedge clk); #1;
         c++;
      end
      start_run_i = 1'b0;
      check("done_timeout", fin, 1'b1);
      check("words", accepted, exp_words);
      check("issued", issued, exp_words);
      check("sb_empty", sb.size(), 0);
      if (n > 0) check("done_after_last", done_cyc, last_acc + 1);
      else       check("done_zero_start", done_cyc, start_cyc + 1);
      if (mode == 0 && n > 0) begin
         check("ce_back_to_back", last_ce - first_ce, n - 1);
         check("valid_back_to_back", last_acc - first_acc, n - 1);
      end
      check("idle_after", {idle_o, run_o, done_o}, 3'b100);
      @(negedge clk); sample();
      check("done_pulses", done_cnt, 1);
      sb.delete();
   endtask

   typedef struct {
      int n;
      int mode;
      int restart_at;
      int exp_words;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int c;
      vecs[0] = '{4,   0, -1, 4};
      vecs[1] = '{256, 1, -1, 256};
      vecs[2] = '{3,   2, -1, 3};
      vecs[3] = '{0,   0, -1, 0};
      vecs[4] = '{8,   0,  3, 8};
      vecs[5] = '{300, 0, -1, 300};
      for (int i = 0; i < 256; i++) mem[i] = word(i);
      held = 0; infl = 0;

      #1 reset_n = 1'b0;
      #2 check_reset_outputs("reset_initial");
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      for (int v = 0; v < 6; v++)
         run_case(vecs[v].n, vecs[v].mode, vecs[v].restart_at, vecs[v].exp_words);

      // Abort a run of 10 once five words have been delivered
      @(posedge clk); #1;
      m_ready_i = 1'b1;
      begin_run(10);
      @(negedge clk); sample();
      @(posedge clk); #1;
      start_run_i = 1'b0;
      c = 0;
      while (accepted < 5 && c < 100) begin
         @(negedge clk); sample();
         if (accepted < 5) begin
            @(posedge clk); #1;
         end
         c++;
      end
      check("abort_reached", accepted, 5);
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("reset_mid_run");
      @(posedge clk); #1;
      check_reset_outputs("reset_held");
      reset_n = 1'b1;
      sb.delete();
      held = 0; infl = 0; stall_prev = 1'b0;
      run_case(2, 0, -1, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
